// File: rtl/sr_latch_bank_pkg.sv
// Shared definitions for the sr_latch_bank: conflict-mode encodings and the
// per-channel next-state rule used by both the RTL and the bench model.
package sr_pkg;

  localparam int unsigned SR_MODE_SET_DOM = 0;
  localparam int unsigned SR_MODE_RST_DOM = 1;
  localparam int unsigned SR_MODE_HOLD    = 2;
  localparam int unsigned SR_MODE_TOGGLE  = 3;

  // Priority: clr, lone set, lone reset, conflict rule, hold.
  function automatic logic sr_next(input logic        clr,
                                   input logic        init,
                                   input logic        s,
                                   input logic        r,
                                   input logic        q,
                                   input int unsigned mode);
    logic nxt;
    nxt = q;
    if (clr) begin
      nxt = init;
    end else if (s && !r) begin
      nxt = 1'b1;
    end else if (r && !s) begin
      nxt = 1'b0;
    end else if (s && r) begin
      case (mode)
        SR_MODE_SET_DOM: nxt = 1'b1;
        SR_MODE_RST_DOM: nxt = 1'b0;
        SR_MODE_TOGGLE:  nxt = ~q;
        default:         nxt = q;
      endcase
    end
    return nxt;
  endfunction

endpackage

// File: rtl/sr_latch_bank_if.sv
// Request/status bundle of the sr_latch_bank; master drives requests, slave is the bank.
interface sr_latch_bank_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 8
);
  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] r;
  logic             clr;
  logic             cnt_clr;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] qbar;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic             conflict;
  logic [CNT_W-1:0] conflict_cnt;

  modport master (
    output s, r, clr, cnt_clr,
    input  q, qbar, rise, fall, conflict, conflict_cnt
  );

  modport slave (
    input  s, r, clr, cnt_clr,
    output q, qbar, rise, fall, conflict, conflict_cnt
  );
endinterface

// File: rtl/sr_latch_bank_cell.sv
// One sr_latch_bank channel: stored bit, registered edge pulses and conflict flag.
module sr_cell
  import sr_pkg::*;
#(
  parameter int unsigned MODE = SR_MODE_SET_DOM,
  parameter logic        INIT = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_s,
  input  logic i_r,
  input  logic i_clr,
  output logic o_q,
  output logic o_rise,
  output logic o_fall,
  output logic o_conflict
);

  logic r_q;
  logic r_rise;
  logic r_fall;
  logic r_conflict;
  logic w_q_next;

  assign w_q_next = sr_next(i_clr, INIT, i_s, i_r, r_q, MODE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q        <= INIT;
      r_rise     <= 1'b0;
      r_fall     <= 1'b0;
      r_conflict <= 1'b0;
    end else begin
      r_q        <= w_q_next;
      r_rise     <= ~r_q & w_q_next;
      r_fall     <= r_q & ~w_q_next;
      // A clear cycle never registers as a conflict.
      r_conflict <= i_s & i_r & ~i_clr;
    end
  end

  assign o_q        = r_q;
  assign o_rise     = r_rise;
  assign o_fall     = r_fall;
  assign o_conflict = r_conflict;

endmodule

// File: rtl/sr_latch_bank.sv
// Bank of WIDTH clocked set/reset cells with edge pulses and a saturating conflict counter.
// Define SR_LATCH_BANK_SYNC_EN to add a two-flop synchroniser on s/r for asynchronous sources.
module sr_latch_bank
  import sr_pkg::*;
#(
  parameter int unsigned      WIDTH      = 8,
  parameter int unsigned      MODE       = SR_MODE_SET_DOM,
  parameter bit               ACTIVE_LOW = 1'b0,
  parameter logic [WIDTH-1:0] INIT       = '0,
  parameter int unsigned      CNT_W      = 8
) (
  input logic           clk,
  input logic           rst_n,
  sr_latch_bank_if.slave bus
);

  logic [WIDTH-1:0] w_s_e;
  logic [WIDTH-1:0] w_r_e;
  logic [WIDTH-1:0] w_s;
  logic [WIDTH-1:0] w_r;
  logic [WIDTH-1:0] w_q;
  logic [WIDTH-1:0] w_rise;
  logic [WIDTH-1:0] w_fall;
  logic [WIDTH-1:0] w_conflict;
  logic             w_conflict_any;
  logic [CNT_W-1:0] r_cnt;

  assign w_s_e = ACTIVE_LOW ? ~bus.s : bus.s;
  assign w_r_e = ACTIVE_LOW ? ~bus.r : bus.r;

`ifdef SR_LATCH_BANK_SYNC_EN
  logic [WIDTH-1:0] r_s_meta;
  logic [WIDTH-1:0] r_s_sync;
  logic [WIDTH-1:0] r_r_meta;
  logic [WIDTH-1:0] r_r_sync;

  // Synchronised after inversion so reset value 0 always means "inactive".
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s_meta <= '0;
      r_s_sync <= '0;
      r_r_meta <= '0;
      r_r_sync <= '0;
    end else begin
      r_s_meta <= w_s_e;
      r_s_sync <= r_s_meta;
      r_r_meta <= w_r_e;
      r_r_sync <= r_r_meta;
    end
  end

  assign w_s = r_s_sync;
  assign w_r = r_r_sync;
`else
  assign w_s = w_s_e;
  assign w_r = w_r_e;
`endif

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    sr_cell #(
      .MODE (MODE),
      .INIT (INIT[i])
    ) u_cell (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_s        (w_s[i]),
      .i_r        (w_r[i]),
      .i_clr      (bus.clr),
      .o_q        (w_q[i]),
      .o_rise     (w_rise[i]),
      .o_fall     (w_fall[i]),
      .o_conflict (w_conflict[i])
    );
  end

  assign w_conflict_any = |w_conflict;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (bus.cnt_clr) begin
      r_cnt <= '0;
    end else if (w_conflict_any && (r_cnt != {CNT_W{1'b1}})) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign bus.q            = w_q;
  assign bus.qbar         = ~w_q;
  assign bus.rise         = w_rise;
  assign bus.fall         = w_fall;
  assign bus.conflict     = w_conflict_any;
  assign bus.conflict_cnt = r_cnt;

endmodule

// File: tb/tb_sr_latch_bank.sv
// Directed self-checking bench for sr_latch_bank: six instances cover every conflict
// mode, a narrow saturating counter and active-low inputs.
module tb_sr_latch_bank;
  import sr_pkg::*;

`ifdef SR_LATCH_BANK_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] s, r, s_al, r_al;
  logic       clr, cnt_clr;
  int         checks = 0;
  int         failures = 0;

  always #5 clk = ~clk;

  sr_latch_bank_if #(.WIDTH(4), .CNT_W(8)) if_m0 ();
  sr_latch_bank_if #(.WIDTH(4), .CNT_W(8)) if_m1 ();
  sr_latch_bank_if #(.WIDTH(4), .CNT_W(8)) if_m2 ();
  sr_latch_bank_if #(.WIDTH(4), .CNT_W(8)) if_m3 ();
  sr_latch_bank_if #(.WIDTH(4), .CNT_W(2)) if_sat ();
  sr_latch_bank_if #(.WIDTH(4), .CNT_W(8)) if_al ();

  assign if_m0.s  = s;  assign if_m0.r  = r;  assign if_m0.clr  = clr; assign if_m0.cnt_clr  = cnt_clr;
  assign if_m1.s  = s;  assign if_m1.r  = r;  assign if_m1.clr  = clr; assign if_m1.cnt_clr  = cnt_clr;
  assign if_m2.s  = s;  assign if_m2.r  = r;  assign if_m2.clr  = clr; assign if_m2.cnt_clr  = cnt_clr;
  assign if_m3.s  = s;  assign if_m3.r  = r;  assign if_m3.clr  = clr; assign if_m3.cnt_clr  = cnt_clr;
  assign if_sat.s = s;  assign if_sat.r = r;  assign if_sat.clr = clr; assign if_sat.cnt_clr = cnt_clr;
  assign if_al.s  = s_al; assign if_al.r = r_al; assign if_al.clr = clr; assign if_al.cnt_clr = cnt_clr;

  sr_latch_bank #(.WIDTH(4), .MODE(SR_MODE_SET_DOM), .ACTIVE_LOW(1'b0), .INIT(4'b1010), .CNT_W(8))
    u_m0 (.clk(clk), .rst_n(rst_n), .bus(if_m0));
  sr_latch_bank #(.WIDTH(4), .MODE(SR_MODE_RST_DOM), .ACTIVE_LOW(1'b0), .INIT(4'b0000), .CNT_W(8))
    u_m1 (.clk(clk), .rst_n(rst_n), .bus(if_m1));
  sr_latch_bank #(.WIDTH(4), .MODE(SR_MODE_HOLD), .ACTIVE_LOW(1'b0), .INIT(4'b0000), .CNT_W(8))
    u_m2 (.clk(clk), .rst_n(rst_n), .bus(if_m2));
  sr_latch_bank #(.WIDTH(4), .MODE(SR_MODE_TOGGLE), .ACTIVE_LOW(1'b0), .INIT(4'b0000), .CNT_W(8))
    u_m3 (.clk(clk), .rst_n(rst_n), .bus(if_m3));
  sr_latch_bank #(.WIDTH(4), .MODE(SR_MODE_SET_DOM), .ACTIVE_LOW(1'b0), .INIT(4'b0000), .CNT_W(2))
    u_sat (.clk(clk), .rst_n(rst_n), .bus(if_sat));
  sr_latch_bank #(.WIDTH(4), .MODE(SR_MODE_SET_DOM), .ACTIVE_LOW(1'b1), .INIT(4'b0000), .CNT_W(8))
    u_al (.clk(clk), .rst_n(rst_n), .bus(if_al));

  logic [3:0] q_mode [4];
  logic       cf_mode [4];
  logic [7:0] cnt_mode [4];
  assign q_mode[0] = if_m0.q;  assign cf_mode[0] = if_m0.conflict;  assign cnt_mode[0] = if_m0.conflict_cnt;
  assign q_mode[1] = if_m1.q;  assign cf_mode[1] = if_m1.conflict;  assign cnt_mode[1] = if_m1.conflict_cnt;
  assign q_mode[2] = if_m2.q;  assign cf_mode[2] = if_m2.conflict;  assign cnt_mode[2] = if_m2.conflict_cnt;
  assign q_mode[3] = if_m3.q;  assign cf_mode[3] = if_m3.conflict;  assign cnt_mode[3] = if_m3.conflict_cnt;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    s = 4'b0000; r = 4'b0000; s_al = 4'b1111; r_al = 4'b1111; clr = 1'b0; cnt_clr = 1'b0;
    repeat (n) tick();
  endtask

  task automatic test_reset();
    s = 4'b0000; r = 4'b0000; s_al = 4'b1111; r_al = 4'b1111; clr = 1'b0; cnt_clr = 1'b0;
    rst_n = 1'b0;
    #12;
    checks++; if (if_m0.q !== 4'b1010) begin failures++; $display("FAIL reset_q got=%b exp=1010", if_m0.q); end
    checks++; if (if_m0.qbar !== 4'b0101) begin failures++; $display("FAIL reset_qbar got=%b exp=0101", if_m0.qbar); end
    checks++; if (if_m0.rise !== 4'b0000) begin failures++; $display("FAIL reset_rise got=%b exp=0000", if_m0.rise); end
    checks++; if (if_m0.fall !== 4'b0000) begin failures++; $display("FAIL reset_fall got=%b exp=0000", if_m0.fall); end
    checks++; if (if_m0.conflict !== 1'b0) begin failures++; $display("FAIL reset_conflict got=%b exp=0", if_m0.conflict); end
    checks++; if (if_m0.conflict_cnt !== 8'd0) begin failures++; $display("FAIL reset_cnt got=%0d exp=0", if_m0.conflict_cnt); end
    checks++; if (if_al.q !== 4'b0000) begin failures++; $display("FAIL reset_al_q got=%b exp=0000", if_al.q); end
    @(negedge clk);
    rst_n = 1'b1;
    idle(LAT + 1);
    // No pulses on reset exit with idle inputs.
    checks++; if (if_m0.rise !== 4'b0000 || if_m0.q !== 4'b1010) begin
      failures++; $display("FAIL reset_exit q=%b rise=%b exp q=1010 rise=0000", if_m0.q, if_m0.rise);
    end
  endtask

  task automatic test_set_reset();
    r = 4'b1111; tick(); idle(LAT + 1);
    checks++; if (if_m0.q !== 4'b0000) begin failures++; $display("FAIL sr_clear_all got=%b exp=0000", if_m0.q); end
    s = 4'b0001; tick(); s = 4'b0000;
    repeat (LAT - 1) tick();
    checks++; if (if_m0.q !== 4'b0001) begin failures++; $display("FAIL sr_set_q got=%b exp=0001", if_m0.q); end
    checks++; if (if_m0.qbar !== 4'b1110) begin failures++; $display("FAIL sr_set_qbar got=%b exp=1110", if_m0.qbar); end
    checks++; if (if_m0.rise !== 4'b0001) begin failures++; $display("FAIL sr_set_rise got=%b exp=0001", if_m0.rise); end
    tick();
    checks++; if (if_m0.rise !== 4'b0000 || if_m0.q !== 4'b0001) begin
      failures++; $display("FAIL sr_rise_drop q=%b rise=%b exp q=0001 rise=0000", if_m0.q, if_m0.rise);
    end
    r = 4'b0001; tick(); r = 4'b0000;
    repeat (LAT - 1) tick();
    checks++; if (if_m0.q !== 4'b0000) begin failures++; $display("FAIL sr_reset_q got=%b exp=0000", if_m0.q); end
    checks++; if (if_m0.fall !== 4'b0001) begin failures++; $display("FAIL sr_reset_fall got=%b exp=0001", if_m0.fall); end
    tick();
    checks++; if (if_m0.fall !== 4'b0000) begin failures++; $display("FAIL sr_fall_drop got=%b exp=0000", if_m0.fall); end
  endtask

  task automatic test_modes();
    logic [2:0] exp_bits [4];
    int idx;
    exp_bits[0] = 3'b111; exp_bits[1] = 3'b000; exp_bits[2] = 3'b000; exp_bits[3] = 3'b101;
    idle(LAT + 1);
    for (int c = 0; c <= 2 + LAT; c++) begin
      s = (c < 3) ? 4'b0001 : 4'b0000;
      r = s;
      tick();
      idx = c + 1 - LAT;
      if (idx >= 0 && idx < 3) begin
        for (int m = 0; m < 4; m++) begin
          checks++; if (q_mode[m] !== {3'b000, exp_bits[m][idx]}) begin
            failures++; $display("FAIL mode%0d_q cyc=%0d got=%b exp=%b", m, idx, q_mode[m], {3'b000, exp_bits[m][idx]});
          end
          checks++; if (cf_mode[m] !== 1'b1) begin
            failures++; $display("FAIL mode%0d_conflict cyc=%0d got=%b exp=1", m, idx, cf_mode[m]);
          end
        end
        checks++; if (if_m3.rise !== ((idx == 1) ? 4'b0000 : 4'b0001)) begin
          failures++; $display("FAIL toggle_rise cyc=%0d got=%b", idx, if_m3.rise);
        end
      end
    end
    for (int m = 0; m < 4; m++) begin
      checks++; if (cnt_mode[m] !== 8'd3) begin
        failures++; $display("FAIL mode%0d_cnt got=%0d exp=3", m, cnt_mode[m]);
      end
    end
  endtask

  task automatic test_saturate();
    idle(LAT + 1);
    cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
    checks++; if (if_sat.conflict_cnt !== 2'd0) begin failures++; $display("FAIL sat_cnt_clr got=%0d exp=0", if_sat.conflict_cnt); end
    s = 4'b0001; r = 4'b0001;
    repeat (5) tick();
    idle(LAT + 1);
    checks++; if (if_sat.conflict_cnt !== 2'd3) begin failures++; $display("FAIL sat_cnt got=%0d exp=3", if_sat.conflict_cnt); end
    checks++; if (if_m0.conflict_cnt !== 8'd5) begin failures++; $display("FAIL wide_cnt got=%0d exp=5", if_m0.conflict_cnt); end
    s = 4'b0001; r = 4'b0001; cnt_clr = 1'b1;
    repeat (LAT + 2) tick();
    checks++; if (if_sat.conflict !== 1'b1 || if_sat.conflict_cnt !== 2'd0) begin
      failures++; $display("FAIL sat_clr_wins conflict=%b cnt=%0d exp conflict=1 cnt=0", if_sat.conflict, if_sat.conflict_cnt);
    end
    idle(LAT + 2);
  endtask

  task automatic test_clear();
    // m0 sits at 0001 after the set-dominant conflicts; clr restores INIT=1010.
    s = 4'b1111; r = 4'b1111; clr = 1'b1;
    for (int k = 0; k <= LAT; k++) begin
      tick();
      if (k == 0) begin
        checks++; if (if_m0.q !== 4'b1010 || if_m0.rise !== 4'b1010 || if_m0.fall !== 4'b0001) begin
          failures++; $display("FAIL clr_init q=%b rise=%b fall=%b exp 1010/1010/0001", if_m0.q, if_m0.rise, if_m0.fall);
        end
      end
      checks++; if (if_m1.q !== 4'b0000 || if_m1.rise !== 4'b0000 || if_m1.conflict !== 1'b0) begin
        failures++; $display("FAIL clr_hold k=%0d q=%b rise=%b conflict=%b exp 0000/0000/0", k, if_m1.q, if_m1.rise, if_m1.conflict);
      end
    end
    idle(LAT + 2);
    s = 4'b1111; tick(); idle(LAT + 1);
    checks++; if (if_m1.q !== 4'b1111) begin failures++; $display("FAIL clr_preset got=%b exp=1111", if_m1.q); end
    clr = 1'b1; tick(); clr = 1'b0;
    checks++; if (if_m1.q !== 4'b0000 || if_m1.fall !== 4'b1111) begin
      failures++; $display("FAIL clr_fall q=%b fall=%b exp 0000/1111", if_m1.q, if_m1.fall);
    end
    tick();
    checks++; if (if_m1.fall !== 4'b0000) begin failures++; $display("FAIL clr_fall_drop got=%b exp=0000", if_m1.fall); end
  endtask

  task automatic test_active_low();
    idle(LAT + 1);
    checks++; if (if_al.q !== 4'b0000) begin failures++; $display("FAIL al_idle got=%b exp=0000", if_al.q); end
    s_al = 4'b1110;
    repeat (LAT - 1) tick();
    checks++; if (if_al.q !== 4'b0000) begin failures++; $display("FAIL al_early got=%b exp=0000", if_al.q); end
    tick();
    checks++; if (if_al.q !== 4'b0001 || if_al.rise !== 4'b0001) begin
      failures++; $display("FAIL al_set q=%b rise=%b exp 0001/0001", if_al.q, if_al.rise);
    end
    s_al = 4'b1111; r_al = 4'b1110; tick(); r_al = 4'b1111;
    repeat (LAT) tick();
    checks++; if (if_al.q !== 4'b0000) begin failures++; $display("FAIL al_reset got=%b exp=0000", if_al.q); end
  endtask

  initial begin
    test_reset();
    test_set_reset();
    test_modes();
    test_saturate();
    test_clear();
    test_active_low();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
